// File: rtl/glyph_upc_decoder.sv
// Recovers the 3-bit item UPC from a stream of six active-low 7-segment glyphs.
// The result is held until it is acknowledged; a partial frame is dropped after an idle gap.
module glyph_upc_decoder #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] GLYPH,
    input  logic       glyph_valid,
    output logic       glyph_ready,
    output logic [2:0] UPC,
    output logic       upc_valid,
    output logic       upc_err,
    input  logic       upc_ack,
    output logic       frame_drop
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_RESULT  = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    // Item rows are stored DU0 in the most significant slice so the literals read left to right.
    function automatic logic [41:0] item_row(input logic [2:0] item);
        logic [41:0] row;
        case (item)
            3'd0:    row = {7'b1000110, 7'b1000000, 7'b0001110, 7'b0001110, 7'b0000110, 7'b0000110};
            3'd1:    row = {7'b0001001, 7'b1000001, 7'b0000011, 7'b1000110, 7'b0001000, 7'b0001100};
            3'd2:    row = {7'b1000110, 7'b0001000, 7'b1001000, 7'b0100001, 7'b1000111, 7'b0000110};
            3'd3:    row = {7'b0001100, 7'b1000000, 7'b0001100, 7'b1111111, 7'b1000110, 7'b0100001};
            3'd4:    row = {7'b0001100, 7'b0001001, 7'b1000000, 7'b1001000, 7'b0000110, 7'b1111111};
            3'd5:    row = {7'b0000011, 7'b0000110, 7'b0100001, 7'b0001100, 7'b0001000, 7'b1001000};
            default: row = 42'd0;
        endcase
        return row;
    endfunction

    function automatic logic [6:0] glyph_at(input logic [2:0] item, input logic [2:0] pos);
        logic [41:0] row;
        logic [6:0]  g;
        row = item_row(item);
        case (pos)
            3'd0:    g = row[41:35];
            3'd1:    g = row[34:28];
            3'd2:    g = row[27:21];
            3'd3:    g = row[20:14];
            3'd4:    g = row[13:7];
            3'd5:    g = row[6:0];
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    state_t      state_q;
    logic [2:0]  pos_q;
    logic [5:0]  mask_q;
    logic [7:0]  idle_q;
    logic        glyph_ready_q;
    logic [2:0]  upc_q;
    logic        upc_valid_q;
    logic        upc_err_q;
    logic        frame_drop_q;

    logic        accept_s;
    logic [5:0]  match_s;
    logic [5:0]  mask_d;
    logic [7:0]  idle_inc_s;
    logic [2:0]  res_code_s;
    logic        res_err_s;

    assign accept_s   = glyph_valid && glyph_ready_q;
    assign idle_inc_s = idle_q + 8'd1;

    // Compare the offered glyph against every item at the current position.
    always_comb begin
        match_s = 6'd0;
        for (int i = 0; i < 6; i++) begin
            match_s[i] = (GLYPH == glyph_at(3'(i), pos_q));
        end
        mask_d = mask_q & match_s;
    end

    // Map the surviving candidate to its item code; no survivor means error.
    always_comb begin
        res_code_s = 3'b000;
        res_err_s  = 1'b0;
        case (mask_d)
            6'b000001: res_code_s = 3'b000;
            6'b000010: res_code_s = 3'b001;
            6'b000100: res_code_s = 3'b011;
            6'b001000: res_code_s = 3'b100;
            6'b010000: res_code_s = 3'b101;
            6'b100000: res_code_s = 3'b110;
            default:   res_err_s  = 1'b1;
        endcase
    end

    // Frame collection, result hold and idle-timeout FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_COLLECT;
            pos_q         <= 3'd0;
            mask_q        <= 6'b111111;
            idle_q        <= 8'd0;
            glyph_ready_q <= 1'b1;
            upc_q         <= 3'b000;
            upc_valid_q   <= 1'b0;
            upc_err_q     <= 1'b0;
            frame_drop_q  <= 1'b0;
        end else begin
            frame_drop_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (accept_s) begin
                        idle_q <= 8'd0;
                        mask_q <= mask_d;
                        if (pos_q == 3'd5) begin
                            state_q       <= ST_RESULT;
                            glyph_ready_q <= 1'b0;
                            upc_valid_q   <= 1'b1;
                            upc_q         <= res_code_s;
                            upc_err_q     <= res_err_s;
                        end else begin
                            pos_q <= pos_q + 3'd1;
                        end
                    end else if (pos_q != 3'd0) begin
                        if (idle_inc_s == TIMEOUT_C) begin
                            pos_q        <= 3'd0;
                            mask_q       <= 6'b111111;
                            idle_q       <= 8'd0;
                            frame_drop_q <= 1'b1;
                        end else begin
                            idle_q <= idle_inc_s;
                        end
                    end else begin
                        idle_q <= 8'd0;
                    end
                end
                ST_RESULT: begin
                    if (upc_ack) begin
                        state_q       <= ST_COLLECT;
                        pos_q         <= 3'd0;
                        mask_q        <= 6'b111111;
                        idle_q        <= 8'd0;
                        glyph_ready_q <= 1'b1;
                        upc_q         <= 3'b000;
                        upc_valid_q   <= 1'b0;
                        upc_err_q     <= 1'b0;
                    end else begin
                        upc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_COLLECT;
                    pos_q         <= 3'd0;
                    mask_q        <= 6'b111111;
                    idle_q        <= 8'd0;
                    glyph_ready_q <= 1'b1;
                    upc_q         <= 3'b000;
                    upc_valid_q   <= 1'b0;
                    upc_err_q     <= 1'b0;
                end
            endcase
        end
    end

    assign glyph_ready = glyph_ready_q;
    assign UPC         = upc_q;
    assign upc_valid   = upc_valid_q;
    assign upc_err     = upc_err_q;
    assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_glyph_upc_decoder.sv
// Directed bench for glyph_upc_decoder: table frames, error frame, timeout, back-pressure and async reset.
module tb_glyph_upc_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] GLYPH;
    logic       glyph_valid;
    logic       glyph_ready;
    logic [2:0] UPC;
    logic       upc_valid;
    logic       upc_err;
    logic       upc_ack;
    logic       frame_drop;

    int vectors = 0;
    int miscompares = 0;

    glyph_upc_decoder #(.TIMEOUT(15)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .GLYPH       (GLYPH),
        .glyph_valid (glyph_valid),
        .glyph_ready (glyph_ready),
        .UPC         (UPC),
        .upc_valid   (upc_valid),
        .upc_err     (upc_err),
        .upc_ack     (upc_ack),
        .frame_drop  (frame_drop)
    );

    always #5 clk = ~clk;

    localparam logic [41:0] F_COFFEE = {7'b1000110, 7'b1000000, 7'b0001110, 7'b0001110, 7'b0000110, 7'b0000110};
    localparam logic [41:0] F_HUBCAP = {7'b0001001, 7'b1000001, 7'b0000011, 7'b1000110, 7'b0001000, 7'b0001100};
    localparam logic [41:0] F_CANDLE = {7'b1000110, 7'b0001000, 7'b1001000, 7'b0100001, 7'b1000111, 7'b0000110};
    localparam logic [41:0] F_POPCD  = {7'b0001100, 7'b1000000, 7'b0001100, 7'b1111111, 7'b1000110, 7'b0100001};
    localparam logic [41:0] F_PHONE  = {7'b0001100, 7'b0001001, 7'b1000000, 7'b1001000, 7'b0000110, 7'b1111111};
    localparam logic [41:0] F_BEDPAN = {7'b0000011, 7'b0000110, 7'b0100001, 7'b0001100, 7'b0001000, 7'b1001000};
    localparam logic [41:0] F_BADCOF = {7'b1000110, 7'b1000000, 7'b0001110, 7'b0001110, 7'b0000110, 7'b1111111};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers glyphs first..last of a frame on consecutive cycles.
    task automatic send_part(input logic [41:0] frame, input int first, input int last);
        logic [41:0] f;
        f = frame;
        for (int i = first; i <= last; i++) begin
            GLYPH       = f[41 - 7*i -: 7];
            glyph_valid = 1'b1;
            tick();
        end
        glyph_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [2:0] code, input logic err);
        chk({tag, "_valid"}, 32'(upc_valid), 32'd1);
        chk({tag, "_upc"},   32'(UPC),       32'(code));
        chk({tag, "_err"},   32'(upc_err),   32'(err));
        chk({tag, "_ready"}, 32'(glyph_ready), 32'd0);
    endtask

    task automatic ack_result();
        upc_ack = 1'b1;
        tick();
        upc_ack = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(upc_valid),   32'd0);
        chk({tag, "_err"},   32'(upc_err),     32'd0);
        chk({tag, "_upc"},   32'(UPC),         32'd0);
        chk({tag, "_ready"}, 32'(glyph_ready), 32'd1);
        chk({tag, "_drop"},  32'(frame_drop),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [41:0] frames [6];
        logic [2:0]  codes  [6];
        frames[0] = F_COFFEE; codes[0] = 3'b000;
        frames[1] = F_HUBCAP; codes[1] = 3'b001;
        frames[2] = F_CANDLE; codes[2] = 3'b011;
        frames[3] = F_POPCD;  codes[3] = 3'b100;
        frames[4] = F_PHONE;  codes[4] = 3'b101;
        frames[5] = F_BEDPAN; codes[5] = 3'b110;

        reset_n     = 1'b0;
        GLYPH       = 7'b1111111;
        glyph_valid = 1'b0;
        upc_ack     = 1'b0;
        #12;
        check_idle("reset");
        reset_n = 1'b1;
        tick();

        // COFFEE with a held result, then acknowledge.
        send_part(F_COFFEE, 0, 5);
        check_result("coffee", 3'b000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_result("coffee_hold", 3'b000, 1'b0);
        end
        ack_result();
        check_idle("coffee_ack");

        // All six items back-to-back, each acked on its first valid cycle.
        for (int k = 0; k < 6; k++) begin
            send_part(frames[k], 0, 5);
            check_result($sformatf("item%0d", k), codes[k], 1'b0);
            ack_result();
        end
        check_idle("items_done");

        // Corrupted last glyph yields an error result.
        send_part(F_BADCOF, 0, 5);
        check_result("badcof", 3'b000, 1'b1);
        ack_result();
        check_idle("badcof_ack");

        // 15-cycle gap after three glyphs drops the frame.
        send_part(F_COFFEE, 0, 2);
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("gap15_nodrop", 32'(frame_drop), 32'd0);
        end
        tick();
        chk("gap15_drop", 32'(frame_drop), 32'd1);
        chk("gap15_ready", 32'(glyph_ready), 32'd1);
        tick();
        chk("gap15_drop_end", 32'(frame_drop), 32'd0);
        send_part(F_PHONE, 0, 5);
        check_result("phone_after_drop", 3'b101, 1'b0);
        ack_result();

        // 14-cycle gap keeps the frame alive.
        send_part(F_PHONE, 0, 2);
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("gap14_nodrop", 32'(frame_drop), 32'd0);
        end
        send_part(F_PHONE, 3, 5);
        chk("gap14_drop", 32'(frame_drop), 32'd0);
        check_result("phone_gap14", 3'b101, 1'b0);
        ack_result();

        // Glyph offered while a result is pending is held off until after the ack.
        send_part(F_POPCD, 0, 5);
        check_result("popcd", 3'b100, 1'b0);
        GLYPH       = 7'b0000011;
        glyph_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_result("pend_hold", 3'b100, 1'b0);
        end
        upc_ack = 1'b1;
        tick();
        upc_ack = 1'b0;
        chk("pend_ack_valid", 32'(upc_valid),   32'd0);
        chk("pend_ack_ready", 32'(glyph_ready), 32'd1);
        send_part(F_BEDPAN, 0, 5);
        check_result("bedpan_after_ack", 3'b110, 1'b0);
        ack_result();

        // Asynchronous reset mid-frame.
        send_part(F_HUBCAP, 0, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_midframe");
        #2;
        reset_n = 1'b1;
        tick();
        send_part(F_CANDLE, 0, 5);
        check_result("candle_after_reset", 3'b011, 1'b0);

        // Asynchronous reset while a result is held.
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_result");
        #2;
        reset_n = 1'b1;
        tick();
        send_part(F_HUBCAP, 0, 5);
        check_result("hubcap_after_reset", 3'b001, 1'b0);
        ack_result();
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
